fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_addr  output  32  byte address of the requested word, equal to the current PC.
REQ-007 imem_rsp_valid  input  1  response data valid; at most one outstanding request.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 redirect_valid  input  1  branch/jump/flush redirect from a later stage.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 fd_valid  output  1  fetch/decode slot holds a valid instruction.
REQ-012 fd_ready  input  1  IF/ID register accepts the slot; low means stall.
REQ-013 fd_pc  output  32  PC of the slot instruction.
REQ-014 fd_instruction  output  32  instruction word of the slot.
REQ-015 fd_next_pc  output  32  fd_pc + 4, modulo 2^32.

Function
REQ-016 States SHALL be REQ, WAIT, DRAIN (plus TRAP under REQ-033); fd_* outputs SHALL be registered.
REQ-017 In REQ, imem_req_valid SHALL be 1 when (!fd_valid || fd_ready) && !redirect_valid, else 0.
REQ-018 REQ -> WAIT when imem_req_valid && imem_req_ready; otherwise stay in REQ.
REQ-019 Slot consumption: fd_valid && fd_ready with no load in the same cycle SHALL clear fd_valid next cycle.
REQ-020 WAIT with imem_rsp_valid and no redirect SHALL load fd_pc=PC, fd_instruction=imem_rsp_data, fd_next_pc=PC+4, fd_valid=1; PC<=PC+4; -> REQ.
REQ-021 Fetch-to-slot latency with a zero-wait memory SHALL be 2 cycles (request cycle, response cycle); throughput is one instruction per 2 cycles.
REQ-022 fd_* SHALL stay constant while fd_valid && !fd_ready.
REQ-023 redirect_valid in any state SHALL load PC<=redirect_pc and clear fd_valid next cycle; this takes priority over slot load and PC increment.
REQ-024 Redirect in REQ: no request issued that cycle; stay REQ.
REQ-025 Redirect in WAIT without imem_rsp_valid: -> DRAIN; with imem_rsp_valid in the same cycle: response discarded, -> REQ.
REQ-026 DRAIN: imem_req_valid=0; first imem_rsp_valid SHALL be discarded, -> REQ; a redirect in DRAIN updates PC and stays in DRAIN unless rsp arrives the same cycle (then -> REQ).
REQ-027 PC increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000; fd_next_pc wraps likewise.
REQ-028 imem_rsp_valid in REQ SHALL be ignored.

Reset
REQ-029 Reset SHALL set PC=RESET_PC, state=REQ, fd_valid=0, fd_pc=0, fd_instruction=0, fd_next_pc=0.
REQ-030 Reset SHALL override redirect and responses in the same cycle.
REQ-031 Reset mid-request (WAIT/DRAIN) SHALL return to REQ; memory responses arriving in the cycle after reset SHALL be ignored (state REQ per REQ-028).
REQ-032 imem_req_valid SHALL be 0 in the reset cycle.

Configuration
REQ-033 FETCH_MISALIGN_TRAP_EN defined: extra output fd_misaligned (1 bit, reset 0); redirect with redirect_pc[1:0]!=0 -> TRAP; TRAP issues no request, loads slot once with fd_pc=PC, fd_instruction=32'h0000_0013, fd_misaligned=1, fd_valid=1, then waits for the next redirect; in states other than TRAP and DRAIN, a redirect is handled per REQ-023..REQ-026.
REQ-034 FETCH_MISALIGN_TRAP_EN undefined: no fd_misaligned port; redirect_pc[1:0] SHALL be forced to 2'b00 when loaded into PC.

Verification
REQ-035 Reset, then fd_ready=1 and a zero-wait memory returning 32'h00500093 at address 0 -> imem_addr=0; 2 cycles later fd_pc=0, fd_instruction=32'h00500093, fd_next_pc=4; next imem_addr=4.
REQ-036 Hold fd_ready=0 for 5 cycles with fd_valid=1 -> fd_* unchanged, imem_req_valid=0; on release, the next request to PC+4 issues in the same cycle.
REQ-037 redirect_valid with redirect_pc=32'h0000_0100 while in WAIT; the response arrives 3 cycles later -> response dropped, fd_valid stays 0, next imem_addr=32'h0000_0100.
REQ-038 PC=32'hFFFF_FFFC, fetch completes -> fd_next_pc=0, next imem_addr=0.
REQ-039 FETCH_MISALIGN_TRAP_EN: redirect_pc=32'h0000_0102 -> no request, fd_misaligned=1, fd_instruction=32'h0000_0013; without the macro -> imem_addr=32'h0000_0100.
REQ-040 Assert reset in WAIT, then deliver a response 1 cycle after reset -> fd_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word request at a time to instruction
// memory and places the returned word into a registered fetch/decode slot.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect trap).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fd_valid,
    input  logic        fd_ready,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_instruction,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic [31:0] fd_next_pc,
    output logic        fd_misaligned
`else
    output logic [31:0] fd_next_pc
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fd_valid_q, fd_valid_d;
    logic [31:0] fd_pc_q, fd_pc_d;
    logic [31:0] fd_instr_q, fd_instr_d;
    logic [31:0] fd_next_pc_q, fd_next_pc_d;
    logic [31:0] redirect_tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fd_mis_q, fd_mis_d;
    logic        redirect_mis;

    // Misaligned targets are kept verbatim so the trap slot reports them.
    assign redirect_tgt = redirect_pc;
    assign redirect_mis = (redirect_pc[1:0] != 2'b00);
    assign fd_misaligned = fd_mis_q;
`else
    // Without the trap, the PC can only ever hold word-aligned addresses.
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign imem_addr      = pc_q;
    assign fd_valid       = fd_valid_q;
    assign fd_pc          = fd_pc_q;
    assign fd_instruction = fd_instr_q;
    assign fd_next_pc     = fd_next_pc_q;

    // Next-state, PC, slot update and request generation.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        fd_valid_d     = fd_valid_q;
        fd_pc_d        = fd_pc_q;
        fd_instr_d     = fd_instr_q;
        fd_next_pc_d   = fd_next_pc_q;
        imem_req_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fd_mis_d       = fd_mis_q;
`endif

        // A consumed slot empties unless something below reloads it.
        if (fd_valid_q && fd_ready) begin
            fd_valid_d = 1'b0;
        end

        case (state_q)
            S_REQ: begin
                // Only fetch when the slot will be free to take the result.
                imem_req_valid = (!fd_valid_q || fd_ready) && !redirect_valid && !reset;
                if (imem_req_valid && imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    // Response (if any) belongs to the old path.
                    state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid) begin
                    fd_valid_d   = 1'b1;
                    fd_pc_d      = pc_q;
                    fd_instr_d   = imem_rsp_data;
                    fd_next_pc_d = pc_q + 32'd4;
                    pc_d         = pc_q + 32'd4;
                    state_d      = S_REQ;
                end
            end
            S_DRAIN: begin
                // Swallow the one response still in flight.
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_TRAP: begin
                // Present a single NOP tagged misaligned, then park.
                if (!fd_mis_q && !redirect_valid) begin
                    fd_valid_d   = 1'b1;
                    fd_pc_d      = pc_q;
                    fd_instr_d   = NOP_INSN;
                    fd_next_pc_d = pc_q + 32'd4;
                    fd_mis_d     = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect wins over slot load and PC increment in every state.
        if (redirect_valid) begin
            pc_d       = redirect_tgt;
            fd_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fd_mis_d   = 1'b0;
            if (redirect_mis) begin
                state_d = S_TRAP;
            end else if (state_q == S_TRAP) begin
                state_d = S_REQ;
            end
`endif
        end
    end

    // State, PC and fetch/decode slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            fd_valid_q   <= 1'b0;
            fd_pc_q      <= 32'd0;
            fd_instr_q   <= 32'd0;
            fd_next_pc_q <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fd_mis_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fd_valid_q   <= fd_valid_d;
            fd_pc_q      <= fd_pc_d;
            fd_instr_q   <= fd_instr_d;
            fd_next_pc_q <= fd_next_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fd_mis_q     <= fd_mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// traffic, all checked against an instruction-stream reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fd_valid;
    logic        fd_ready;
    logic [31:0] fd_pc;
    logic [31:0] fd_instruction;
    logic [31:0] fd_next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fd_misaligned;
`endif

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fd_valid       (fd_valid),
        .fd_ready       (fd_ready),
        .fd_pc          (fd_pc),
        .fd_instruction (fd_instruction),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fd_next_pc     (fd_next_pc),
        .fd_misaligned  (fd_misaligned)
`else
        .fd_next_pc     (fd_next_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          loads = 0;
    logic [31:0] exp_pc;      // address of the next instruction in program order
    bit          model_on;
    bit          auto_mem;
    bit          mem_pend;
    int          mem_wait;
    int          next_delay;
    logic [31:0] mem_addr;

    // Instruction memory contents; word 0 is the required 32'h00500093.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ (a * 32'h0001_0003);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: memory responds, request rules checked, then the
    // resulting slot is compared against the program-order stream.
    task automatic tick();
        logic        p_reset, p_redir, p_rsp, p_fv, p_fr, acc;
        logic [31:0] p_rpc, p_pc, p_ins, p_npc, acc_addr;
        if (auto_mem) begin
            if (mem_pend && mem_wait == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
        end
        #1;
        p_reset  = reset;
        p_redir  = redirect_valid;
        p_rpc    = redirect_pc;
        p_rsp    = imem_rsp_valid;
        p_fv     = fd_valid;
        p_fr     = fd_ready;
        p_pc     = fd_pc;
        p_ins    = fd_instruction;
        p_npc    = fd_next_pc;
        acc      = imem_req_valid && imem_req_ready && !reset;
        acc_addr = imem_addr;
        if (model_on) begin
            if (reset || redirect_valid || (fd_valid && !fd_ready))
                chk("req_gate", 32'(imem_req_valid), 32'd0);
            if (imem_req_valid === 1'b1)
                chk("req_addr", imem_addr, exp_pc);
        end
        @(posedge clk);
        #1;
        if (auto_mem) begin
            if (mem_pend) begin
                if (mem_wait == 0) mem_pend = 1'b0;
                else mem_wait--;
            end
            if (acc) begin
                mem_pend = 1'b1;
                mem_addr = acc_addr;
                mem_wait = next_delay;
            end
        end
        if (p_reset) begin
            exp_pc = RESET_PC;
            if (model_on) chk("rst_clear", 32'(fd_valid), 32'd0);
        end else if (p_redir) begin
            exp_pc = p_rpc & 32'hFFFF_FFFC;
            if (model_on) chk("redir_flush", 32'(fd_valid), 32'd0);
        end else if (model_on) begin
            if (p_fv && !p_fr) begin
                chk("hold_valid", 32'(fd_valid), 32'd1);
                chk("hold_pc", fd_pc, p_pc);
                chk("hold_insn", fd_instruction, p_ins);
                chk("hold_npc", fd_next_pc, p_npc);
            end else if (fd_valid) begin
                chk("load_needs_rsp", 32'(p_rsp), 32'd1);
                chk("slot_pc", fd_pc, exp_pc);
                chk("slot_insn", fd_instruction, mem_word(exp_pc));
                chk("slot_npc", fd_next_pc, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                loads++;
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        fd_ready       = 1'b1;
        model_on       = 1'b1;
        auto_mem       = 1'b0;
        mem_pend       = 1'b0;
        mem_wait       = 0;
        next_delay     = 0;
        mem_addr       = 32'd0;
        exp_pc         = RESET_PC;

        // Reset overrides a concurrent redirect and response.
        tick();
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        chk("rst_fd_valid", 32'(fd_valid), 32'd0);
        chk("rst_fd_pc", fd_pc, 32'd0);
        chk("rst_fd_insn", fd_instruction, 32'd0);
        chk("rst_fd_npc", fd_next_pc, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);

        // First fetch from a zero-wait memory: two cycles to the slot.
        auto_mem = 1'b1;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_addr, 32'd0);
        tick();
        tick();
        chk("first_valid", 32'(fd_valid), 32'd1);
        chk("first_pc", fd_pc, 32'd0);
        chk("first_insn", fd_instruction, 32'h0050_0093);
        chk("first_npc", fd_next_pc, 32'd4);
        chk("second_addr", imem_addr, 32'd4);

        // Stall the slot for five cycles.
        fd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", fd_pc, 32'd0);
            chk("stall_insn", fd_instruction, 32'h0050_0093);
            chk("stall_req", 32'(imem_req_valid), 32'd0);
        end
        fd_ready = 1'b1;
        #1;
        chk("release_req", 32'(imem_req_valid), 32'd1);
        chk("release_addr", imem_addr, 32'd4);
        tick();
        tick();
        chk("second_pc", fd_pc, 32'd4);
        chk("second_insn", fd_instruction, mem_word(32'd4));

        // Redirect in WAIT; the stale response shows up three cycles later.
        auto_mem       = 1'b0;
        imem_rsp_valid = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("drain_no_req", 32'(imem_req_valid), 32'd0);
            tick();
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(32'd8);
        tick();
        imem_rsp_valid = 1'b0;
        chk("drop_valid", 32'(fd_valid), 32'd0);
        #1;
        chk("redir_req", 32'(imem_req_valid), 32'd1);
        chk("redir_addr", imem_addr, 32'h0000_0100);

        // PC wrap at the top of the address space.
        auto_mem       = 1'b1;
        mem_pend       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("wrap_pc", fd_pc, 32'hFFFF_FFFC);
        chk("wrap_npc", fd_next_pc, 32'd0);
        #1;
        chk("wrap_addr", imem_addr, 32'd0);

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
`ifdef FETCH_MISALIGN_TRAP_EN
        model_on = 1'b0;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("trap_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        chk("trap_valid", 32'(fd_valid), 32'd1);
        chk("trap_mis", 32'(fd_misaligned), 32'd1);
        chk("trap_insn", fd_instruction, 32'h0000_0013);
        chk("trap_pc", fd_pc, 32'h0000_0102);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        model_on       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("trap_exit_mis", 32'(fd_misaligned), 32'd0);
`else
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("align_addr", imem_addr, 32'h0000_0100);
`endif

        // Reset while WAIT, stale response one cycle after reset.
        auto_mem       = 1'b0;
        mem_pend       = 1'b0;
        imem_rsp_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(32'h0000_0100);
        tick();
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        chk("post_rst_valid", 32'(fd_valid), 32'd0);
        chk("post_rst_addr", imem_addr, RESET_PC);

        // Randomized traffic: stalls, memory wait states, redirects.
        auto_mem = 1'b1;
        mem_pend = 1'b0;
        loads    = 0;
        for (int i = 0; i < 2000; i++) begin
            fd_ready       = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 2) != 0);
            next_delay     = $urandom_range(0, 2);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            redirect_pc[1:0] = 2'b00;
`endif
            tick();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", 32'(loads > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
